// File: rtl/posit_accumulator.sv
// Posit adder (round-to-nearest-even, saturating, NaR/zero aware) and the valid/ready
// accumulator that folds a stream of posits into one running sum through it.

module posit_adder #(
  parameter int N  = 8,
  parameter int ES = 3
) (
  input  logic [N-1:0] in1_i,
  input  logic [N-1:0] in2_i,
  output logic [N-1:0] sum_o
);

  localparam int G     = N + 2;
  localparam int SW    = N + G + 1;
  localparam int YW    = 2 + ES + SW + N - 1;
  localparam int MAXSC = (N - 2) * (1 << ES);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Splits a positive posit body into its scale (regime*2^ES + exponent) and
  // a significand with the hidden one on top; truncated exponent bits read as zero.
  function automatic void unpack(input logic [N-2:0] body, output int scale,
                                 output logic [N-1:0] sig);
    logic              r0;
    logic              run;
    int                k;
    logic [N+ES-2:0]   ext;
    r0  = body[N-2];
    run = 1'b1;
    k   = 0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && body[i] == r0) k++;
      else run = 1'b0;
    end
    ext   = {body, {ES{1'b0}}} << (k + 1);
    scale = (r0 ? k - 1 : -k) * (1 << ES) + int'(ext[N+ES-2 -: ES]);
    sig   = {1'b1, ext[N-2:0]};
  endfunction

  logic            neg1, neg2, swap, sa, sb;
  logic [N-1:0]    mag1, mag2, sig_a, sig_b;
  logic [N-2:0]    ma, mb;
  int              sc_a, sc_b, diff, p, sc, r;
  logic [SW-1:0]   a_ext, b_full, b_al, sum, norm;
  logic [ES-1:0]   e;
  logic signed [YW-1:0] y;
  logic [N-2:0]    body;
  logic            rnd, stk;

  // NOTE: every variable is assigned on every path through this block before it is
  // read, so no storage (latch) is inferred for any of them.
  always_comb begin
    neg1 = in1_i[N-1];
    neg2 = in2_i[N-1];
    mag1 = neg1 ? -in1_i : in1_i;
    mag2 = neg2 ? -in2_i : in2_i;
    swap = mag2 > mag1;
    sa   = swap ? neg2 : neg1;
    sb   = swap ? neg1 : neg2;
    ma   = swap ? mag2[N-2:0] : mag1[N-2:0];
    mb   = swap ? mag1[N-2:0] : mag2[N-2:0];
    unpack(ma, sc_a, sig_a);
    unpack(mb, sc_b, sig_b);

    diff   = sc_a - sc_b;
    a_ext  = {1'b0, sig_a, {G{1'b0}}};
    b_full = {1'b0, sig_b, {G{1'b0}}};
    // Bits shifted out of the smaller operand are jammed into the LSB as a sticky bit.
    if (diff >= SW) b_al = SW'(1);
    else            b_al = (b_full >> diff) | SW'(|(b_full << (SW - diff)));
    sum = (sa == sb) ? a_ext + b_al : a_ext - b_al;

    p = 0;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) p = i;
    end
    sc   = sc_a + p - (N + G - 1);
    norm = sum << (SW - p);

    // Regime run built by sign-filling shift: 10.. fills ones, 01.. fills zeros.
    r = sc >>> ES;
    e = ES'(sc);
    y = {((r >= 0) ? 2'b10 : 2'b01), e, norm, {(N-1){1'b0}}};
    y = y >>> ((r >= 0) ? r : -r - 1);

    body = y[YW-1 -: N-1];
    rnd  = y[YW-N];
    stk  = |y[YW-N-1:0];
    body = body + {{(N-2){1'b0}}, rnd & (body[0] | stk)};
    if (sc > MAXSC)       body = '1;
    else if (sc < -MAXSC) body = {{(N-2){1'b0}}, 1'b1};

    if (in1_i == NAR || in2_i == NAR) sum_o = NAR;
    else if (in1_i == '0)             sum_o = in2_i;
    else if (in2_i == '0)             sum_o = in1_i;
    else if (sum == '0)               sum_o = '0;
    else                              sum_o = sa ? -{1'b0, body} : {1'b0, body};
  end

endmodule

module posit_accumulator #(
  parameter  int N         = 8,
  parameter  int ES        = 3,
  parameter  int MAX_TERMS = 16,
  localparam int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_trunc
);

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCEPT, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d, op_q, op_d, add_sum;
  logic [CW-1:0]   count_q, count_d, count_inc;
  logic            nar_q, nar_d, last_q, last_d, trunc_q, trunc_d, at_max;

  posit_adder #(.N(N), .ES(ES)) u_adder (
    .in1_i (acc_q),
    .in2_i (op_q),
    .sum_o (add_sum)
  );

  assign count_inc = count_q + CW'(1);
  assign at_max    = (count_inc == CW'(MAX_TERMS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    count_d = count_q;
    nar_d   = nar_q;
    last_d  = last_q;
    trunc_d = trunc_q;
    unique case (state_q)
      IDLE: begin
        acc_d   = '0;
        count_d = '0;
        nar_d   = 1'b0;
        last_d  = 1'b0;
        trunc_d = 1'b0;
        state_d = ACCEPT;
      end
      ACCEPT: begin
        if (in_valid) begin
          op_d    = in_data;
          count_d = count_inc;
          last_d  = in_last | at_max;
          trunc_d = at_max & ~in_last;
          state_d = ADD;
        end
      end
      ADD: begin
        // Once NaR enters the sum it stays, whatever the adder would make of it.
        if (op_q == NAR || nar_q) begin
          acc_d = NAR;
          nar_d = 1'b1;
        end else begin
          acc_d = add_sum;
        end
        state_d = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      count_q <= '0;
      nar_q   <= 1'b0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      count_q <= count_d;
      nar_q   <= nar_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
    end
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q   : '0;
  assign out_count = out_valid ? count_q : '0;
  assign out_trunc = out_valid & trunc_q;

endmodule

// File: tb/tb_posit_accumulator.sv
// Randomised scoreboard bench for posit_accumulator: a value-level posit model predicts
// each sum; a monitor compares every accepted result against the queued prediction.

module tb_posit_accumulator;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int MT = 16;
  localparam int CW = $clog2(MT + 1);

  logic          Clock;
  logic          nReset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  posit_accumulator #(.N(N), .ES(ES), .MAX_TERMS(MT)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] count;
    logic       trunc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_acc, m_cnt;
  bit   m_nar;
  bit   rand_ready;
  int   r_prev, r_len, r_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at t=%0t", name, $time);
  endtask

  // Exact value of an nb-bit posit in units of 2^-64 (NaR excluded).
  function automatic logic signed [127:0] pval(input int x_in, input int nb);
    logic signed [127:0] v;
    int x, neg, i, r0, k, rg, e, fb, f, sh;
    x = x_in & ((1 << nb) - 1);
    if (x == 0) return 0;
    neg = (x >> (nb - 1)) & 1;
    if (neg != 0) x = ((1 << nb) - x) & ((1 << nb) - 1);
    i  = nb - 2;
    r0 = (x >> i) & 1;
    k  = 0;
    while (i >= 0 && ((x >> i) & 1) == r0) begin
      k++;
      i--;
    end
    i--;
    rg = (r0 != 0) ? k - 1 : -k;
    e  = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? ((x >> i) & 1) : 0);
      i--;
    end
    fb = (i >= 0) ? i + 1 : 0;
    f  = x & ((1 << fb) - 1);
    sh = rg * (1 << ES) + e - fb + 64;
    v  = 128'((1 << fb) | f);
    v  = v << sh;
    return (neg != 0) ? -v : v;
  endfunction

  // Nearest 8-bit posit; the decision point between neighbours p and p+1 is the
  // 9-bit posit p:1, ties go to the even pattern; never rounds to zero or NaR.
  function automatic int round8(input logic signed [127:0] v);
    logic signed [127:0] m, mid;
    int r;
    if (v == 0) return 0;
    m = (v < 0) ? -v : v;
    if (m >= pval(127, 8))     r = 127;
    else if (m <= pval(1, 8))  r = 1;
    else begin
      r = 1;
      while (pval(r + 1, 8) <= m) r++;
      if (pval(r, 8) != m) begin
        mid = pval((r << 1) | 1, 9);
        if (m > mid || (m == mid && (r & 1) != 0)) r++;
      end
    end
    return (v < 0) ? ((256 - r) & 255) : r;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_nar = 0;
  endtask

  task automatic model_op(input int d, input bit l);
    m_cnt++;
    if (d == 128 || m_nar) begin
      m_nar = 1;
      m_acc = 128;
    end else begin
      m_acc = round8(pval(m_acc, 8) + pval(d, 8));
    end
    if (l || m_cnt == MT) begin
      sb_q.push_back('{data: 8'(m_acc), count: 8'(m_cnt), trunc: (m_cnt == MT) && !l});
      model_reset();
    end
  endtask

  task automatic send(input int d, input bit l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = l;
    forever begin
      @(negedge Clock);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        timeout_fail("in_ready_wait");
        break;
      end
    end
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic feed(input int d, input bit l);
    model_op(d, l);
    send(d, l);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge Clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      timeout_fail("drain");
      sb_q.delete();
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_out_trunc"}, 32'(out_trunc), 32'd0);
  endtask

  always @(negedge Clock) begin
    if (nReset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data",  32'(out_data),  32'(mon_e.data));
        check("out_count", 32'(out_count), 32'(mon_e.count));
        check("out_trunc", 32'(out_trunc), 32'(mon_e.trunc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nReset     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    model_reset();
    #2;
    check_outputs_zero("reset");
    #10 nReset = 1'b1;
    @(posedge Clock);
    #1;

    // 1+1+1+1 = 4
    for (int i = 0; i < 4; i++) feed(8'h40, i == 3);
    drain();
    // x + (-x) = 0, then a single operand passes through
    feed(8'h40, 0);
    feed(8'hC0, 1);
    feed(8'h44, 1);
    drain();
    // NaR stays sticky
    feed(8'h40, 0);
    feed(8'h80, 0);
    feed(8'h40, 1);
    drain();
    // 17 zeros: first 16 close by truncation, the 17th opens the next sum
    for (int i = 0; i < 17; i++) feed(8'h00, i == 16);
    drain();

    // Back-pressure: result held, input ignored, restart two cycles after release
    out_ready = 1'b0;
    feed(8'h44, 1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge Clock);
        n++;
      end
      if (!out_valid) timeout_fail("out_valid_wait");
    end
    in_valid = 1'b1;
    in_data  = 8'h40;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data",  32'(out_data),  32'h44);
      check("hold_out_count", 32'(out_count), 32'd1);
      check("hold_out_trunc", 32'(out_trunc), 32'd0);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge Clock);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    check("restart_in_ready_1", 32'(in_ready), 32'd0);
    @(negedge Clock);
    check("restart_in_ready_2", 32'(in_ready), 32'd1);
    drain();

    // Reset in the ADD cycle of the second operand discards the partial sum
    feed(8'h40, 0);
    feed(8'h40, 0);
    nReset = 1'b0;
    #1;
    check_outputs_zero("midsum_reset");
    model_reset();
    #2 nReset = 1'b1;
    @(posedge Clock);
    #1;
    feed(8'h44, 1);
    drain();

    // Randomised streams with random back-pressure
    rand_ready = 1'b1;
    r_prev     = 8'h40;
    fork
      begin
        for (int s = 0; s < 60; s++) begin
          r_len = $urandom_range(1, 20);
          for (int i = 0; i < r_len; i++) begin
            case ($urandom_range(0, 3))
              0:       r_d = (256 - r_prev) & 255;
              1:       r_d = $urandom_range(8'h30, 8'h50);
              default: r_d = $urandom_range(0, 255);
            endcase
            if (r_d == 128 && $urandom_range(0, 3) != 0) r_d = 8'h40;
            feed(r_d, i == r_len - 1);
            r_prev = r_d;
          end
        end
        rand_ready = 1'b0;
      end
      begin
        while (1) begin
          @(posedge Clock);
          #1;
          if (!rand_ready) break;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
